// File: rtl/serializer_pkg.sv
// Shared types and parameter checks for the block serializer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serializer_pkg;

  // IDLE: nothing held. SEND: a block is held and its words are being emitted.
  typedef enum logic {IDLE, SEND} ser_state_t;

  // Legal geometry: the block splits evenly into a power-of-two count of at
  // least two words, so the word index is a plain binary counter.
  function automatic bit widths_legal(input int in_w, input int out_w);
    int n;
    if (out_w <= 0 || in_w <= 0) return 1'b0;
    if ((in_w % out_w) != 0) return 1'b0;
    n = in_w / out_w;
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/selec_t.sv
// Word-slice selector: picks word `index` out of a wide block.
// Latency: combinational, zero cycles.
// Backpressure: none; forced to zero while reset is high.
//
// Ports:
//   reset - forces word to 0 while high
//   data  - INPUT_WIDTH-bit block
//   index - word number, 0 = LSBs
//   word  - selected OUT_WIDTH-bit slice
module selec_t
  import serializer_pkg::*;
#(
  parameter int INPUT_WIDTH = 128,
  parameter int OUT_WIDTH   = 32,
  parameter int NUM_WORDS   = INPUT_WIDTH / OUT_WIDTH,
  parameter int IDX_W       = $clog2(NUM_WORDS)
) (
  input  logic                   reset,
  input  logic [INPUT_WIDTH-1:0] data,
  input  logic [IDX_W-1:0]       index,
  output logic [OUT_WIDTH-1:0]   word
);

  always_comb begin
    word = '0;
    if (!reset) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (index == IDX_W'(i)) begin
          word = data[i*OUT_WIDTH +: OUT_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/block_serializer.sv
// Streams a wide block out as OUT_WIDTH-bit words, word 0 (LSBs) first.
// Latency: word 0 one cycle after the input handshake; NUM_WORDS cycles/block.
// Backpressure: out_ready low stalls the current word; in_ready only opens
//   when idle or when the last word is taken, so blocks chain with no bubble.
//
// Ports:
//   clk, reset                      - clock, async active-high reset
//   in_data/in_valid/in_ready       - block input handshake
//   out_data/out_valid/out_ready    - word output handshake
//   out_index, out_last             - current word number, last-word flag
//   busy                            - a block is held
module block_serializer
  import serializer_pkg::*;
#(
  parameter int INPUT_WIDTH = 128,
  parameter int OUT_WIDTH   = 32,
  localparam int NUM_WORDS  = INPUT_WIDTH / OUT_WIDTH,
  localparam int IDX_W      = $clog2(NUM_WORDS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INPUT_WIDTH-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_index,
  output logic                   out_last,
  output logic                   busy
);

  if (!widths_legal(INPUT_WIDTH, OUT_WIDTH)) begin : g_bad_params
    $error("block_serializer: INPUT_WIDTH/OUT_WIDTH must be a power of two >= 2");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  ser_state_t             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [INPUT_WIDTH-1:0] held_q, held_d;

  logic out_fire;
  logic in_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      held_q  <= held_d;
    end
  end

  always_comb begin
    out_valid = (state_q == SEND);
    busy      = (state_q == SEND);
    out_last  = out_valid && (idx_q == LAST_IDX);
    out_index = idx_q;
    out_fire  = out_valid && out_ready;
    // Ready opens on the cycle the last word leaves, which is what lets the
    // next block load without an idle cycle in between.
    in_ready  = !reset && ((state_q == IDLE) || (out_fire && out_last));
    in_fire   = in_valid && in_ready;

    state_d = state_q;
    idx_d   = idx_q;
    held_d  = held_q;

    if (out_fire) begin
      if (out_last) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end

    // A load overrides the end-of-block return to IDLE.
    if (in_fire) begin
      held_d  = in_data;
      idx_d   = '0;
      state_d = SEND;
    end
  end

  selec_t #(
    .INPUT_WIDTH(INPUT_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .NUM_WORDS  (NUM_WORDS),
    .IDX_W      (IDX_W)
  ) u_sel (
    .reset(reset),
    .data (held_q),
    .index(idx_q),
    .word (out_data)
  );

endmodule

// File: tb/tb_block_serializer.sv
// Self-checking bench for block_serializer (128-bit blocks, 32-bit words).
// Reference model: a queue of expected words built from each accepted block.
// Inputs change 1 time unit after posedge; outputs compared at negedge.
module tb_block_serializer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [127:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [1:0]   out_index;
  logic         out_last;
  logic         busy;

  int total = 0;
  int bad = 0;
  int nacc = 0;

  logic [31:0] wq[$];
  int          iq[$];

  localparam logic [127:0] BLK_BASIC = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] BLK_B     = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;

  block_serializer #(.INPUT_WIDTH(128), .OUT_WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_index(out_index),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: compare outputs to the model, advance the model with the
  // handshakes that will happen at the next rising edge.
  task automatic cycle();
    bit exp_vld;
    bit exp_rdy;
    logic [127:0] blk;
    @(negedge clk);
    exp_vld = (wq.size() != 0);
    exp_rdy = (wq.size() == 0) || (wq.size() == 1 && out_ready);
    check("out_valid", out_valid, exp_vld);
    check("busy", busy, exp_vld);
    check("in_ready", in_ready, exp_rdy);
    if (exp_vld) begin
      check("out_data", out_data, wq[0]);
      check("out_index", out_index, iq[0]);
      check("out_last", out_last, iq[0] == 3);
    end else begin
      check("out_last_idle", out_last, 1'b0);
    end
    if (exp_vld && out_ready) begin
      void'(wq.pop_front());
      void'(iq.pop_front());
      nacc++;
    end
    if (in_valid && exp_rdy) begin
      blk = in_data;
      for (int k = 0; k < 4; k++) begin
        wq.push_back(blk[32*k +: 32]);
        iq.push_back(k);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic load(input logic [127:0] blk);
    in_data  = blk;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_index", out_index, 2'd0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Idle: ready stays up, nothing emitted
    cycles(10);

    // Basic stream with out_ready held high
    out_ready = 1'b1;
    load(BLK_BASIC);
    cycles(5);

    // Back-to-back: B offered throughout A, loads on A's last word
    load(BLK_BASIC);
    nacc = 0;
    in_data  = BLK_B;
    in_valid = 1'b1;
    cycles(4);
    in_valid = 1'b0;
    cycles(4);
    check("b2b_words_in_8", nacc, 8);
    cycles(1);

    // Backpressure on word 1
    load(BLK_BASIC);
    cycle();
    out_ready = 1'b0;
    cycles(3);
    out_ready = 1'b1;
    cycles(4);

    // Garbage input while word 2 is presented
    load(BLK_BASIC);
    cycles(2);
    in_data  = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycles(3);

    // Asynchronous reset while word 2 is presented
    load(BLK_BASIC);
    cycles(2);
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_out_data", out_data, 32'h0);
    check("arst_in_ready", in_ready, 1'b0);
    wq.delete();
    iq.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    cycle();
    load(BLK_B);
    cycles(5);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom_range(0, 9) < 7);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycles(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/block_serializer.md
# block_serializer

Streams a wide block, such as a 128-bit cipher state or a key, out as a sequence of OUT_WIDTH-bit words over a valid/ready handshake. Word 0 (the LSBs) goes first.
- Sits directly upstream of the word-slice consumers in the datapath: it owns the word-index counter and drives the slice selector with it.
- Accepts a new block on the cycle the last word of the current block is taken, so a stream of blocks runs with zero bubbles.

## Interface
Parameters:
- INPUT_WIDTH, default 128: block width in bits. Must be a multiple of OUT_WIDTH.
- OUT_WIDTH, default 32: word width in bits.
- NUM_WORDS (derived, not overridable) = INPUT_WIDTH/OUT_WIDTH. Must be a power of two and at least 2.
- IDX_W (derived) = $clog2(NUM_WORDS).

Ports:
- clk, input, 1: the single clock. All state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- in_data, input, INPUT_WIDTH: block to serialize. Sampled only on an input handshake.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a new input.
- out_data, output, OUT_WIDTH: current word, equal to held[OUT_WIDTH*out_index +: OUT_WIDTH].
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: downstream accepts the word.
- out_index, output, IDX_W: index of the current word.
- out_last, output, 1: high when out_valid is high and out_index == NUM_WORDS-1.
- busy, output, 1: high when the state is SEND.

## Operation
- State machine, two states:
  - IDLE: no block held.
  - SEND: a block is held in `held` and words are being emitted.
- Input handshake fires when in_valid && in_ready.
  - On the handshake: held <= in_data, idx <= 0, state <= SEND.
- in_ready = !reset && (state == IDLE || (out_valid && out_ready && out_last)). It is combinational from registered state.
- Output handshake fires when out_valid && out_ready.
  - idx < NUM_WORDS-1: idx <= idx+1.
  - idx == NUM_WORDS-1 with no simultaneous input handshake: state <= IDLE and idx <= 0.
  - idx == NUM_WORDS-1 with a simultaneous input handshake: the new block loads, idx <= 0, state stays SEND.
- out_valid = (state == SEND).
- No output handshake means idx and held hold their values.
- The index counter never wraps past NUM_WORDS-1. Reaching the last word always ends the block or reloads.
- in_data is ignored whenever in_ready is low, regardless of in_valid.
- Reset asserted at any time, including mid-block, discards the held block. No partial word is emitted after reset.

## Timing
- Reset values: state = IDLE, idx = 0, held = 0, out_valid = 0, out_last = 0, out_index = 0, out_data = 0, busy = 0, in_ready = 0 while reset is high.
- in_ready is 1 in the first cycle after reset deasserts.
- Input handshake in cycle T: word 0 is presented (out_valid = 1) in cycle T+1.
- With out_ready held at 1: word k appears in cycle T+1+k, and out_last is high in cycle T+NUM_WORDS.
- Back-to-back blocks: word 0 of the next block appears in the cycle after the last word of the previous one. Throughput is NUM_WORDS cycles per block.
- Stall: while out_valid && !out_ready, out_data, out_index and out_last hold stable. out_valid never drops until its word is accepted.
- out_data is combinational from the held and idx registers through the slice mux. There is no extra register stage.

## Structure
- Shared package serializer_pkg contains:
  - typedef enum logic {IDLE, SEND} ser_state_t;
  - a function checking the parameter legality rules.
- Elaboration-time assertion: INPUT_WIDTH % OUT_WIDTH == 0, NUM_WORDS a power of two, NUM_WORDS >= 2.
- Sub-module: instantiate the existing selec_t slice selector for the out_data mux.
  - Its index port is driven by idx.
  - Its reset port is tied to the block's reset, so out_data is 0 during reset.
- All registers live in a single always_ff with the asynchronous reset.

## Test plan
All scenarios use INPUT_WIDTH = 128 and OUT_WIDTH = 32.
- Basic: reset, then load 128'h44444444_33333333_22222222_11111111 with out_ready = 1 -> words 11111111, 22222222, 33333333, 44444444 on 4 consecutive cycles starting at T+1; out_last only on 44444444; busy drops the following cycle.
- Back-to-back: load block A, hold in_valid with block B = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA -> in_ready pulses on A's last word; AAAAAAAA appears in the very next cycle; 8 words in 8 cycles.
- Backpressure: drop out_ready for 3 cycles while word 1 is presented -> out_data stays 22222222 and out_index stays 1; out_valid stays 1; in_ready stays 0; the sequence resumes intact.
- Input ignored while busy: drive in_valid with garbage during word 2 -> no load; output sequence unchanged.
- Reset mid-block: assert reset asynchronously (not on a clock edge) during word 2 -> out_valid and busy go 0 immediately with out_data = 0; after release, in_ready = 1 and a new block starts at word 0.
- Idle: in_valid = 0 for 10 cycles after reset -> out_valid = 0 and in_ready = 1 throughout.
